// File: rtl/mac_psum_requant_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_psum_requant_if                                          |
// | Description : Bus bundle between the adder tree / config source and the    |
// |               partial-sum accumulate + requantize stage.                   |
// |   master : drives clr, cfg_len, cfg_shift, cfg_relu, bias, vld_i, din;     |
// |            observes vld_o, dout, sum_o                                     |
// |   slave  : the requant stage (mirror image of master)                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mac_psum_requant_if #(
  parameter int IN_W  = 22,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
);
  logic                    clr;
  logic [7:0]              cfg_len;
  logic [4:0]              cfg_shift;
  logic                    cfg_relu;
  logic signed [ACC_W-1:0] bias;
  logic                    vld_i;
  logic signed [IN_W-1:0]  din;
  logic                    vld_o;
  logic signed [OUT_W-1:0] dout;
  logic signed [ACC_W-1:0] sum_o;

  modport master (
    output clr, cfg_len, cfg_shift, cfg_relu, bias, vld_i, din,
    input  vld_o, dout, sum_o
  );

  modport slave (
    input  clr, cfg_len, cfg_shift, cfg_relu, bias, vld_i, din,
    output vld_o, dout, sum_o
  );
endinterface
`default_nettype wire

// File: rtl/mac_psum_requant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_psum_requant                                             |
// | Description : Accumulates cfg_len signed partial sums into one channel     |
// |               value, adds a bias, then rounds/shifts, optional ReLU and    |
// |               saturates to OUT_W. Two register stages after the last beat. |
// |   clk  : clock, rising edge                                                |
// |   rst  : synchronous active-high reset                                     |
// |   bus  : slave side of mac_psum_requant_if (config, beats in, result out)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mac_psum_requant #(
  parameter int IN_W  = 22,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mac_psum_requant_if.slave     bus
);

  localparam logic signed [ACC_W:0] c_out_max = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] c_out_min = -c_out_max - (ACC_W+1)'(1);

  // Group accumulation stage
  logic [7:0]              cnt_q, cnt_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [7:0]              len_q, len_d;
  logic [4:0]              shift_q, shift_d;
  logic                    relu_q, relu_d;
  // Stage 1: completed group sum
  logic [ACC_W-1:0]        grp_sum_q, grp_sum_d;
  logic                    grp_vld_q, grp_vld_d;
  // Stage 2: requantized output
  logic                    vld_q, vld_d;
  logic [OUT_W-1:0]        dout_q, dout_d;
  logic [ACC_W-1:0]        sum_q, sum_d;

  logic [ACC_W-1:0]        din_ext;
  logic                    first_beat;
  logic                    last_beat;
  logic [7:0]              cfg_len_eff;
  logic [7:0]              len_cur;
  logic [7:0]              cnt_cur;
  logic [ACC_W-1:0]        acc_next;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   shifted;
  logic signed [ACC_W:0]   rq;
  logic [OUT_W-1:0]        dout_sat;

  always_comb begin
    din_ext     = {{(ACC_W-IN_W){bus.din[IN_W-1]}}, bus.din};
    // clr makes this cycle look like the start of a fresh group, so a
    // coincident beat becomes the first beat of the new group.
    first_beat  = bus.clr || (cnt_q == 8'd0);
    cfg_len_eff = (bus.cfg_len == 8'd0) ? 8'd1 : bus.cfg_len;
    len_cur     = first_beat ? cfg_len_eff : len_q;
    cnt_cur     = first_beat ? 8'd0 : cnt_q;
    acc_next    = first_beat ? (bus.bias + din_ext) : (acc_q + din_ext);
    last_beat   = bus.vld_i && (cnt_cur == (len_cur - 8'd1));

    cnt_d     = cnt_cur;
    acc_d     = acc_q;
    len_d     = len_q;
    shift_d   = shift_q;
    relu_d    = relu_q;
    grp_sum_d = grp_sum_q;
    grp_vld_d = 1'b0;

    if (bus.vld_i) begin
      acc_d = acc_next;
      cnt_d = last_beat ? 8'd0 : (cnt_cur + 8'd1);
      if (first_beat) begin
        len_d   = cfg_len_eff;
        shift_d = bus.cfg_shift;
        relu_d  = bus.cfg_relu;
      end
      if (last_beat) begin
        grp_sum_d = acc_next;
        grp_vld_d = 1'b1;
      end
    end

    // Stage 2 reads shift_q/relu_q while the group is still in stage 1; a
    // following group can only overwrite them at the same edge that
    // registers this result, so the values seen here belong to this group.
    // One extra bit keeps the rounding add from overflowing.
    sum_wide = {grp_sum_q[ACC_W-1], grp_sum_q};
    rnd      = (ACC_W+1)'(1) << (shift_q - 5'd1);
    shifted  = (sum_wide + rnd) >>> shift_q;
    rq       = (shift_q == 5'd0) ? sum_wide : shifted;
    if (relu_q && (rq < 0)) begin
      rq = '0;
    end
    dout_sat = rq[OUT_W-1:0];
    if (rq > c_out_max) begin
      dout_sat = c_out_max[OUT_W-1:0];
    end else if (rq < c_out_min) begin
      dout_sat = c_out_min[OUT_W-1:0];
    end

    vld_d  = grp_vld_q;
    dout_d = grp_vld_q ? dout_sat : dout_q;
    sum_d  = grp_vld_q ? grp_sum_q : sum_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      len_q     <= 8'd1;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      grp_sum_q <= '0;
      grp_vld_q <= 1'b0;
      vld_q     <= 1'b0;
      dout_q    <= '0;
      sum_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      len_q     <= len_d;
      shift_q   <= shift_d;
      relu_q    <= relu_d;
      grp_sum_q <= grp_sum_d;
      grp_vld_q <= grp_vld_d;
      vld_q     <= vld_d;
      dout_q    <= dout_d;
      sum_q     <= sum_d;
    end
  end

  assign bus.vld_o = vld_q;
  assign bus.dout  = dout_q;
  assign bus.sum_o = sum_q;

endmodule
`default_nettype wire
